ps2_host_receiver: RTL and testbench

PS2_HOST_RECEIVER -- requirements
Module: ps2_host_receiver

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/input_filter.sv | 32 +++
 rtl/ps2_rx_fifo.sv | 58 +++++
 rtl/ps2_host_receiver.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_receiver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types, frame constants and parameter defaults
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    localparam int DEFAULT_FILTER_LENGTH  = 3;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
        return (^data ^ parity) == 1'b1;
    endfunction

endpackage

// File: rtl/input_filter.sv
// rtl/input_filter.sv - glitch filter: output follows input after LENGTH consecutive samples at a new level
module input_filter #(
    parameter logic RESET_VALUE = 1'b1,
    parameter int   LENGTH      = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    localparam int CNT_W = $clog2(LENGTH + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= RESET_VALUE;
            cnt <= '0;
        end else if (d_i != q_o) begin
            if (cnt == CNT_W'(LENGTH - 1)) begin
                q_o <= d_i;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - first-word fall-through receive byte FIFO with overflow pulse
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, pop, wr_en;

    assign full    = (level_o == (PTR_W + 1)'(DEPTH));
    assign valid_o = (level_o != '0);
    assign pop     = pop_ready_i & valid_o;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr_en   = push_i & (~full | pop);
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push_i & full & ~pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_o <= level_o + (PTR_W + 1)'(1);
                2'b01:   level_o <= level_o - (PTR_W + 1)'(1);
                default: level_o <= level_o;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host_receiver.sv
// rtl/ps2_host_receiver.sv - PS/2 device-to-host frame receiver with byte FIFO
// Define PS2_RX_TIMEOUT_EN to build the inter-edge watchdog that aborts stalled frames.
module ps2_host_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LENGTH  = DEFAULT_FILTER_LENGTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          buffer_ready_i,
    output logic [7:0]                    data_o,
    output logic                          data_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          parity_error_o,
    output logic                          frame_error_o,
    output logic                          overflow_o
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    logic [1:0]           clk_sync, data_sync;
    logic                 clk_f, data_f, clk_f_q, fall;
    ps2_state_t           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 push, perr_d, ferr_d;
    logic                 timeout_hit;

    // Raw lines are asynchronous to clk_i; synchronise before filtering
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    input_filter #(.RESET_VALUE(1'b1), .LENGTH(FILTER_LENGTH)) u_clk_filter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (clk_sync[1]),
        .q_o   (clk_f)
    );

    input_filter #(.RESET_VALUE(1'b1), .LENGTH(FILTER_LENGTH)) u_data_filter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (data_sync[1]),
        .q_o   (data_f)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            clk_f_q <= 1'b1;
        end else begin
            clk_f_q <= clk_f;
        end
    end

    assign fall = clk_f_q & ~clk_f;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt <= '0;
        end else if (fall || state_q == ST_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout_hit = (state_q != ST_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    // TIMEOUT_CYCLES has no effect without the watchdog; this is a constant 0
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fall) begin
            case (state_q)
                ST_IDLE:   if (!data_f) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Stop-bit failure takes priority over a parity failure
    always_comb begin
        push   = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (fall && state_q == ST_STOP) begin
            if (!data_f) begin
                ferr_d = 1'b1;
            end else if (!odd_parity_ok(shift_q, parity_q)) begin
                perr_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (!fall && timeout_hit) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   bit_cnt <= '0;
                ST_DATA: begin
                    shift_q <= {data_f, shift_q[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
                ST_PARITY: parity_q <= data_f;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            parity_error_o <= 1'b0;
            frame_error_o  <= 1'b0;
        end else begin
            parity_error_o <= perr_d;
            frame_error_o  <= ferr_d;
        end
    end

    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_ready_i (buffer_ready_i),
        .data_o      (data_o),
        .valid_o     (data_valid_o),
        .level_o     (fifo_level_o),
        .overflow_o  (overflow_o)
    );

endmodule

// File: tb/tb_ps2_host_receiver.sv
// tb/tb_ps2_host_receiver.sv - self-checking bench for ps2_host_receiver against a frame-level model
module tb_ps2_host_receiver;
    import ps2_pkg::*;

    localparam int FILT  = 3;
    localparam int DEPTH = 8;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic       buffer_ready_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic [3:0] fifo_level_o;
    logic       parity_error_o, frame_error_o, overflow_o;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, valid_cycles = 0;
    int ferr_cyc = 0;
    int last_fall_cyc = 0;
    logic [7:0] popped [$];

    logic [7:0] exp_q [$];
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int model_held = 0;
    int chk_idx = 0;

    ps2_host_receiver #(
        .FILTER_LENGTH  (FILT),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ps2_clk_i      (ps2_clk_i),
        .ps2_data_i     (ps2_data_i),
        .buffer_ready_i (buffer_ready_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .fifo_level_o   (fifo_level_o),
        .parity_error_o (parity_error_o),
        .frame_error_o  (frame_error_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (parity_error_o) perr_cnt++;
        if (frame_error_o) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (overflow_o) ovf_cnt++;
        if (data_valid_o) valid_cycles++;
        if (data_valid_o && buffer_ready_i) popped.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Device drives data while the clock is high; host samples on the falling edge
    task automatic send_bits(input logic [FRAME_BITS-1:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(HALF / 2);
                ps2_clk_i = 1'b0;
                wait_cyc(1);
                ps2_clk_i = 1'b1;
                wait_cyc(HALF / 2);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk_i = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    // Frame-level model: outcome from the start/parity/stop rules and buffer occupancy
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
        if (!stop) begin
            exp_ferr++;
        end else if (((^d) ^ par) != 1'b1) begin
            exp_perr++;
        end else if (buffer_ready_i) begin
            exp_q.push_back(d);
        end else if (model_held == DEPTH) begin
            exp_ovf++;
        end else begin
            exp_q.push_back(d);
            model_held++;
        end
        send_bits(make_frame(d, par, stop), FRAME_BITS, glitch_bit);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_perr"}, perr_cnt, exp_perr);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovf"}, ovf_cnt, exp_ovf);
    endtask

    task automatic check_popped(input string tag);
        check({tag, "_pop_count"}, popped.size(), exp_q.size());
        for (int i = chk_idx; i < popped.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), popped[i], exp_q[i]);
        end
        chk_idx = popped.size();
    endtask

    initial begin
        int vbase;
        int f0;
        logic [7:0] d;
        int kind;

        wait_cyc(4);
        check("rst_valid", data_valid_o, 0);
        check("rst_data", data_o, 8'h00);
        check("rst_level", fifo_level_o, 0);
        check("rst_perr", parity_error_o, 0);
        check("rst_ferr", frame_error_o, 0);
        check("rst_ovf", overflow_o, 0);
        rst_i = 1'b1;
        wait_cyc(10);

        buffer_ready_i = 1'b1;
        send_frame(8'h15, 1'b0, 1'b1, -1);
        check_popped("good15");
        check_errs("good15");

        vbase = valid_cycles;
        send_frame(8'h15, 1'b1, 1'b1, -1);
        check_errs("par15");
        check("par15_valid_cycles", valid_cycles, vbase);
        check("par15_level", fifo_level_o, 0);

        send_frame(8'h1C, 1'b0, 1'b0, -1);
        check_errs("stop1c");
        check_popped("stop1c");
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check_popped("good1c");

        buffer_ready_i = 1'b0;
        for (int b = 1; b <= DEPTH; b++) begin
            d = 8'(b);
            send_frame(d, ~^d, 1'b1, -1);
        end
        check_errs("fill8");
        check("fill8_level", fifo_level_o, DEPTH);
        send_frame(8'h09, ~^8'h09, 1'b1, -1);
        check_errs("ovf9");
        check("ovf9_level", fifo_level_o, DEPTH);
        check("hold_valid", data_valid_o, 1);
        check("hold_data", data_o, 8'h01);
        buffer_ready_i = 1'b1;
        model_held = 0;
        wait_cyc(2 * DEPTH);
        check("drain_level", fifo_level_o, 0);
        check_popped("drain");

        send_frame(8'hA5, ~^8'hA5, 1'b1, 3);
        check_popped("glitch");
        check_errs("glitch");

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 5);
            if (kind == 0) send_frame(d, ~^d, 1'b0, -1);
            else if (kind == 1) send_frame(d, ^d, 1'b1, -1);
            else send_frame(d, ~^d, 1'b1, -1);
        end
        check_popped("random");
        check_errs("random");

        f0 = ferr_cnt;
        d = 8'h3C;
        send_bits(make_frame(d, ~^d, 1'b1), 5, -1);
        for (int k = 0; k < 3 * TMO && ferr_cnt == f0; k++) wait_cyc(1);
`ifdef PS2_RX_TIMEOUT_EN
        exp_ferr++;
        check_errs("timeout");
        check("timeout_latency_ok", (ferr_cyc - last_fall_cyc >= TMO) && (ferr_cyc - last_fall_cyc <= TMO + 20), 1);
        send_frame(8'h5A, ~^8'h5A, 1'b1, -1);
        check_popped("after_timeout");
`else
        check_errs("stall_no_timeout");
        check("stall_level", fifo_level_o, 0);
`endif

        d = 8'hC3;
        send_bits(make_frame(d, ~^d, 1'b1), 4, -1);
        rst_i = 1'b0;
        wait_cyc(3);
        check("midrst_valid", data_valid_o, 0);
        check("midrst_level", fifo_level_o, 0);
        rst_i = 1'b1;
        wait_cyc(10);
        check_errs("midrst");
        send_frame(8'h7E, ~^8'h7E, 1'b1, -1);
        check_popped("after_rst");
        check_errs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
